// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared FSM encoding and width helpers for the N-way write-back data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WB_REQ   = 2'd1,
        S_FILL_REQ = 2'd2,
        S_FILL_WR  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Widths for the default geometry (32-bit address, 256-bit line, 16 sets)
    localparam int DEF_OFF_W = clog2(256 / 8);
    localparam int DEF_IDX_W = clog2(16);
    localparam int DEF_TAG_W = 32 - DEF_IDX_W - DEF_OFF_W;

endpackage

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one cache way: tag/valid/dirty/data arrays, async read, single sync write port
module dcache_way
    import dcache_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    parameter int WORD_W = 32,
    parameter int WSEL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              word_we,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0] word,
    input  logic              line_we,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [LINE_W-1:0] line
);

    logic [SETS-1:0]   valid;
    logic [SETS-1:0]   dirty;
    logic [TAG_W-1:0]  tags [SETS];
    logic [LINE_W-1:0] data [SETS];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = data[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (line_we) begin
            valid[wr_idx] <= 1'b1;
            dirty[wr_idx] <= 1'b0;
        end else if (word_we) begin
            dirty[wr_idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid bits gate every use of them
    always_ff @(posedge clk) begin
        if (line_we) begin
            tags[wr_idx] <= line_tag;
            data[wr_idx] <= line;
        end else if (word_we) begin
            data[wr_idx][WORD_W*int'(word_sel) +: WORD_W] <= word;
        end
    end

endmodule

// File: rtl/dcache_nway_wb.sv
// rtl/dcache_nway_wb.sv - N-way set-associative write-back write-allocate data cache with true-LRU ages
module dcache_nway_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFF_W  = clog2(LINE_W / 8);
    localparam int IDX_W  = clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int BYTE_W = clog2(WORD_W / 8);
    localparam int WSEL_W = OFF_W - BYTE_W;
    localparam int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;

    logic              req;
    logic              is_store;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] word_sel;
    logic              unused_addr;

    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign is_store    = p1_MemWrite_i;
    assign idx         = p1_addr_i[OFF_W +: IDX_W];
    assign tag         = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign word_sel    = p1_addr_i[BYTE_W +: WSEL_W];
    assign unused_addr = ^p1_addr_i[BYTE_W-1:0];

    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_dirty;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];

    state_t            state, state_next;
    logic              mem_en, mem_en_next;
    logic              mem_wr, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr, mem_addr_next;
    logic [LINE_W-1:0] mem_line, mem_line_next;
    logic              capture;
    logic              line_we;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic [WAY_W-1:0]  victim_q;
    logic [LINE_W-1:0] fill_line;
    logic [AGE_W-1:0]  age [SETS][WAYS];

    logic [WAYS-1:0]   match;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [WAY_W-1:0]  victim;
    logic              found_invalid;
    logic              victim_dirty;
    logic              complete;
    logic              word_we;
    logic [IDX_W-1:0]  wr_idx;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LINE_W (LINE_W),
            .WORD_W (WORD_W),
            .WSEL_W (WSEL_W)
        ) u_way (
            .clk      (clk_i),
            .rst      (rst_i),
            .rd_idx   (idx),
            .rd_valid (way_valid[w]),
            .rd_dirty (way_dirty[w]),
            .rd_tag   (way_tag[w]),
            .rd_line  (way_line[w]),
            .wr_idx   (wr_idx),
            .word_we  (word_we && (hit_way == WAY_W'(w))),
            .word_sel (word_sel),
            .word     (p1_data_i),
            .line_we  (line_we && (victim_q == WAY_W'(w))),
            .line_tag (miss_tag),
            .line     (fill_line)
        );
    end

    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = way_valid[w] && (way_tag[w] == tag);
            if (match[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    // A tag present in more than one way is never a legal hit
    assign hit      = req && (match != '0) && ((match & (match - WAYS'(1))) == '0);
    assign hit_line = way_line[hit_way];
    assign p1_data_o  = hit ? hit_line[WORD_W*int'(word_sel) +: WORD_W] : '0;
    assign p1_stall_o = req && (!hit || (state != S_IDLE));
    assign complete   = (state == S_IDLE) && hit;
    assign word_we    = complete && is_store;
    assign wr_idx     = line_we ? miss_idx : idx;

    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !way_valid[w]) begin
                victim        = WAY_W'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age[idx][w] == AGE_W'(WAYS - 1)) begin
                    victim = WAY_W'(w);
                end
            end
        end
    end

    assign victim_dirty = way_valid[victim] && way_dirty[victim];

    always_comb begin
        state_next    = state;
        mem_en_next   = mem_en;
        mem_wr_next   = mem_wr;
        mem_addr_next = mem_addr;
        mem_line_next = mem_line;
        capture       = 1'b0;
        line_we       = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && !hit) begin
                    mem_en_next = 1'b1;
                    if (victim_dirty) begin
                        state_next    = S_WB_REQ;
                        mem_wr_next   = 1'b1;
                        mem_addr_next = {way_tag[victim], idx, {OFF_W{1'b0}}};
                        mem_line_next = way_line[victim];
                    end else begin
                        state_next    = S_FILL_REQ;
                        mem_wr_next   = 1'b0;
                        mem_addr_next = {tag, idx, {OFF_W{1'b0}}};
                    end
                end
            end
            S_WB_REQ: begin
                if (mem_en && mem_ack_i) begin
                    state_next  = S_FILL_REQ;
                    mem_en_next = 1'b0;
                end
            end
            S_FILL_REQ: begin
                // Enable stays low for one cycle after a write-back ack before the refill read
                if (!mem_en) begin
                    mem_en_next   = 1'b1;
                    mem_wr_next   = 1'b0;
                    mem_addr_next = {miss_tag, miss_idx, {OFF_W{1'b0}}};
                end else if (mem_ack_i) begin
                    capture     = 1'b1;
                    mem_en_next = 1'b0;
                    state_next  = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                line_we    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_line  <= '0;
            miss_idx  <= '0;
            miss_tag  <= '0;
            victim_q  <= '0;
            fill_line <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            state    <= state_next;
            mem_en   <= mem_en_next;
            mem_wr   <= mem_wr_next;
            mem_addr <= mem_addr_next;
            mem_line <= mem_line_next;
            if ((state == S_IDLE) && req && !hit) begin
                miss_idx <= idx;
                miss_tag <= tag;
                victim_q <= victim;
            end
            if (capture) begin
                fill_line <= mem_data_i;
            end
            // Ages form a permutation per set: the accessed way becomes 0, younger ways age by one
            if (complete) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age[idx][w] <= '0;
                    end else if (age[idx][w] < age[idx][hit_way]) begin
                        age[idx][w] <= age[idx][w] + AGE_W'(1);
                    end
                end
            end
        end
    end

    assign mem_enable_o = mem_en;
    assign mem_write_o  = mem_wr;
    assign mem_addr_o   = mem_addr;
    assign mem_data_o   = mem_line;

endmodule

// File: tb/tb_dcache_nway_wb.sv
// tb/tb_dcache_nway_wb.sv - scoreboard bench for dcache_nway_wb with a line-wide memory responder
module tb_dcache_nway_wb;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_RD    = 2;
    localparam int K_WB    = 3;

    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [255:0] line;
    } exp_t;

    logic         clk;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic         resp_ack;
    logic         spur_ack;

    int           n_tests;
    int           n_fail;
    int           ack_delay;
    int           resp_k;
    exp_t         exp_q [$];
    logic [255:0] mem_store [logic [31:0]];

    assign mem_ack_i = resp_ack | spur_ack;

    dcache_nway_wb dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Untouched memory holds 0xC0DE_xxxx where xxxx is the word's own byte address
    function automatic logic [255:0] base_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = 32'hC0DE_0000 | ((a + 32'(i * 4)) & 32'h0000_FFFF);
        end
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return base_line(a);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [255:0] l);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.line = l;
        exp_q.push_back(e);
    endtask

    task automatic access(input logic [31:0] a, input logic wr, input logic [31:0] d,
                          input int exp_stall, input string name);
        int cnt;
        cnt = 0;
        @(posedge clk);
        #1;
        p1_addr_i     = a;
        p1_data_i     = d;
        p1_MemRead_i  = !wr;
        p1_MemWrite_i = wr;
        @(negedge clk);
        while (p1_stall_o && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, exp_stall);
        @(posedge clk);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    // Memory responder: acks the ack_delay-th cycle of each enable, abandons if enable drops
    initial begin
        resp_ack   = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (mem_enable_o && !rst_i) begin
                resp_k = 1;
                while (resp_k < ack_delay && mem_enable_o) begin
                    @(negedge clk);
                    resp_k++;
                end
                if (mem_enable_o) begin
                    if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
                    else mem_data_i = mem_line(mem_addr_o);
                    resp_ack = 1'b1;
                    @(negedge clk);
                    resp_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: pops one expectation per memory request start or per completed CPU access
    initial begin
        exp_t e;
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (mem_enable_o && !prev_en) begin
                    if (exp_q.size() == 0) begin
                        chk("mem_unexpected_req", {mem_write_o, mem_addr_o}, '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_kind", mem_write_o ? K_WB : K_RD, e.kind);
                        chk("mem_addr", mem_addr_o, e.addr);
                        if (mem_write_o) chk("mem_wb_line", mem_data_o, e.line);
                    end
                end
                if ((p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o) begin
                    if (exp_q.size() == 0) begin
                        chk("cpu_unexpected_done", p1_addr_i, '1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cpu_kind", p1_MemWrite_i ? K_STORE : K_LOAD, e.kind);
                        chk("cpu_addr", p1_addr_i, e.addr);
                        if (!p1_MemWrite_i) chk("cpu_load_data", p1_data_o, e.data);
                    end
                end
            end
            prev_en = mem_enable_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] l;
        logic [31:0]  a0;
        logic [255:0] d0;
        int           w;
        int           ch_a, ch_d, ch_s;

        n_tests       = 0;
        n_fail        = 0;
        ack_delay     = 3;
        spur_ack      = 1'b0;
        rst_i         = 1'b1;
        p1_addr_i     = '0;
        p1_data_i     = '0;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", p1_stall_o, 0);
        chk("rst_data", p1_data_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_mem_wr", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Cold read, then store hit and read-back
        push(K_RD, 32'h040, 0, 0);
        push(K_LOAD, 32'h040, 32'hC0DE_0040, 0);
        access(32'h040, 1'b0, 0, 5, "t1_cold_stall");
        push(K_STORE, 32'h044, 0, 0);
        access(32'h044, 1'b1, 32'hDEAD_BEEF, 0, "t2_store_stall");
        push(K_LOAD, 32'h044, 32'hDEAD_BEEF, 0);
        access(32'h044, 1'b0, 0, 0, "t2_load_stall");

        // LRU: 0x240 fills the free way, 0x040 touched, 0x440 must evict 0x240
        push(K_RD, 32'h240, 0, 0);
        push(K_LOAD, 32'h240, 32'hC0DE_0240, 0);
        access(32'h240, 1'b0, 0, 5, "t3_fill_240");
        push(K_LOAD, 32'h040, 32'hC0DE_0040, 0);
        access(32'h040, 1'b0, 0, 0, "t3_touch_040");
        push(K_RD, 32'h440, 0, 0);
        push(K_LOAD, 32'h440, 32'hC0DE_0440, 0);
        access(32'h440, 1'b0, 0, 5, "t3_fill_440");
        push(K_LOAD, 32'h040, 32'hC0DE_0040, 0);
        access(32'h040, 1'b0, 0, 0, "t3_040_still_hits");

        // Dirty eviction: write-back of 0x040 precedes refill of 0x640
        push(K_STORE, 32'h040, 0, 0);
        access(32'h040, 1'b1, 32'h1234_5678, 0, "t4_store_stall");
        push(K_LOAD, 32'h440, 32'hC0DE_0440, 0);
        access(32'h440, 1'b0, 0, 0, "t4_age_040");
        l = base_line(32'h040);
        l[31:0]  = 32'h1234_5678;
        l[63:32] = 32'hDEAD_BEEF;
        push(K_WB, 32'h040, 0, l);
        push(K_RD, 32'h640, 0, 0);
        push(K_LOAD, 32'h640, 32'hC0DE_0640, 0);
        access(32'h640, 1'b0, 0, 9, "t4_dirty_stall");

        // Reset during refill drops the request at once and invalidates everything
        ack_delay = 50;
        push(K_RD, 32'h240, 0, 0);
        @(posedge clk);
        #1;
        p1_addr_i    = 32'h240;
        p1_MemRead_i = 1'b1;
        w = 0;
        @(negedge clk);
        while (!mem_enable_o && w < 10) begin
            w++;
            @(negedge clk);
        end
        chk("t5_fill_en", mem_enable_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_rst_drop_en", mem_enable_o, 0);
        p1_MemRead_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        ack_delay = 3;
        l[63:32]  = 32'hDEAD_BEEF;
        push(K_RD, 32'h040, 0, 0);
        push(K_LOAD, 32'h040, 32'h1234_5678, 0);
        access(32'h040, 1'b0, 0, 5, "t5_040_misses");

        // Long write-back stall: memory outputs and stall must hold
        push(K_STORE, 32'h040, 0, 0);
        access(32'h040, 1'b1, 32'hA5A5_A5A5, 0, "t6_store_stall");
        push(K_RD, 32'h240, 0, 0);
        push(K_LOAD, 32'h240, 32'hC0DE_0240, 0);
        access(32'h240, 1'b0, 0, 5, "t6_fill_240");
        l[31:0] = 32'hA5A5_A5A5;
        push(K_WB, 32'h040, 0, l);
        push(K_RD, 32'h440, 0, 0);
        push(K_LOAD, 32'h440, 32'hC0DE_0440, 0);
        ack_delay = 21;
        fork
            access(32'h440, 1'b0, 0, 45, "t6_dirty_stall");
            begin
                w = 0;
                @(negedge clk);
                while (!mem_enable_o && w < 10) begin
                    w++;
                    @(negedge clk);
                end
                chk("t6_wb_write", mem_write_o, 1);
                a0   = mem_addr_o;
                d0   = mem_data_o;
                ch_a = 0;
                ch_d = 0;
                ch_s = 0;
                repeat (19) begin
                    @(negedge clk);
                    if (mem_addr_o !== a0) ch_a++;
                    if (mem_data_o !== d0) ch_d++;
                    if (p1_stall_o !== 1'b1) ch_s++;
                end
                chk("t6_hold_addr_changes", ch_a, 0);
                chk("t6_hold_data_changes", ch_d, 0);
                chk("t6_hold_stall_drops", ch_s, 0);
            end
        join
        ack_delay = 3;

        // A stray ack while idle must start nothing and disturb no line
        @(posedge clk);
        #1;
        spur_ack = 1'b1;
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        @(negedge clk);
        chk("t6_spur_en", mem_enable_o, 0);
        push(K_LOAD, 32'h440, 32'hC0DE_0440, 0);
        access(32'h440, 1'b0, 0, 0, "t6_spur_440_hits");

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
